muldiv_seq: RTL and testbench

- Iterative 32-bit multiply/divide sequencer beside the single-cycle ALU; owns the HI/LO result registers.
- Executes MULT/MULTU/DIV/DIVU over 34 cycles with a start/busy/done handshake.
- The control unit holds the pipeline stalled while busy_o is high.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 tb/tb_muldiv_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit and the multiply/divide sequencer.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::WIDTH);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic             dz_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, dz_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, dz_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi,lo} working register:
// shift-add for multiply, restoring trial-subtract-shift for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    work_o = '0;
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    if (div_i) begin
      // Partial remainder shifted left by one, pulling in the next dividend bit.
      rem_sh = {work_i[2*WIDTH-1:WIDTH], work_i[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd_i};
      if (!trial[WIDTH]) begin
        work_o = {trial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
      end else begin
        work_o = {rem_sh[WIDTH-1:0], work_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add lands in the top bit after the right shift.
      sum    = {1'b0, work_i[2*WIDTH-1:WIDTH]} +
               (work_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      work_o = {sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// 34-cycle sequencer for MULT/MULTU/DIV/DIVU on unsigned magnitudes,
// with sign correction in a single FIX cycle; owns the HI/LO registers.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   raw1_q, raw1_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [W2-1:0]      work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  op_e                op_in;
  logic               sgn1_in, sgn2_in;
  logic [WIDTH-1:0]   mag1_in, mag2_in;
  logic [W2-1:0]      step_out;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (op_is_div(op_q)),
    .work_i (work_q),
    .opnd_i (op_is_div(op_q) ? opb_q : opa_q),
    .work_o (step_out)
  );

  always_comb begin
    op_in   = op_e'(bus.op_i);
    sgn1_in = op_is_signed(op_in) & bus.src1_i[WIDTH-1];
    sgn2_in = op_is_signed(op_in) & bus.src2_i[WIDTH-1];
    mag1_in = sgn1_in ? -bus.src1_i : bus.src1_i;
    mag2_in = sgn2_in ? -bus.src2_i : bus.src2_i;
  end

  // Sign correction of the magnitude result; the most-negative case wraps naturally.
  always_comb begin
    prod_fix = (neg1_q ^ neg2_q) ? -work_q : work_q;
    quo_fix  = (neg1_q ^ neg2_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = neg1_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    raw1_d  = raw1_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start_i) begin
          state_d = RUN;
          cnt_d   = CNT_W'(WIDTH - 1);
          op_d    = op_in;
          opa_d   = mag1_in;
          opb_d   = mag2_in;
          raw1_d  = bus.src1_i;
          neg1_d  = sgn1_in;
          neg2_d  = sgn2_in;
          work_d  = op_is_div(op_in) ? {{WIDTH{1'b0}}, mag1_in}
                                     : {{WIDTH{1'b0}}, mag2_in};
        end
      end
      RUN: begin
        work_d = step_out;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        state_d = DONE;
        if (op_is_div(op_q)) begin
          if (opb_q == '0) begin
            hi_d = raw1_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
            dz_d = 1'b0;
          end
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
          dz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      opa_q   <= '0;
      opb_q   <= '0;
      raw1_q  <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      raw1_q  <= raw1_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy_o = (state_q == RUN) || (state_q == FIX);
  assign bus.done_o = (state_q == DONE);
  assign bus.dz_o   = dz_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against a plain-arithmetic reference.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ehi, elo, ahi, alo;
  logic        edz, adz;
  int          cyc;
  logic        busy_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic, truncating division, remainder follows dividend.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
    longint      sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    mdz = 1'b0;
    case (op)
      2'b00: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          mdz = 1'b1; mlo = 32'hFFFF_FFFF; mhi = a;
        end else if (op == 2'b10) begin
          p = sa / sb; mlo = p[31:0];
          p = sa % sb; mhi = p[31:0];
        end else begin
          mlo = a / b; mhi = a % b;
        end
      end
    endcase
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    check1("busy_after_accept", bus.busy_o, 1'b1);
  endtask

  task automatic wait_done(input int already);
    cyc     = already;
    busy_ok = 1'b1;
    while (cyc < already + 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done_o) break;
      if (!bus.busy_o) busy_ok = 1'b0;
    end
    check("latency", 32'(cyc), 32'd33);
    check1("busy_through_run", busy_ok, 1'b1);
    check1("busy_low_in_done", bus.busy_o, 1'b0);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_hi"}, bus.hi_o, ehi);
    check({tag, "_lo"}, bus.lo_o, elo);
    check1({tag, "_dz"}, bus.dz_o, edz);
  endtask

  task automatic run_check(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    model(op, a, b, ehi, elo, edz);
    start_op(op, a, b);
    wait_done(0);
    check_result(tag);
    @(posedge clk); #1;
    check1("done_single_pulse", bus.done_o, 1'b0);
    check1("idle_not_busy", bus.busy_o, 1'b0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] edges [6];
    edges = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
              32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", bus.busy_o, 1'b0);
    check1("rst_done", bus.done_o, 1'b0);
    check1("rst_dz", bus.dz_o, 1'b0);
    check("rst_hi", bus.hi_o, 32'h0);
    check("rst_lo", bus.lo_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_check("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD);
    check("mult_7_m3_hi_const", bus.hi_o, 32'hFFFF_FFFF);
    check("mult_7_m3_lo_const", bus.lo_o, 32'hFFFF_FFEB);

    run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", bus.hi_o, 32'hFFFF_FFFE);
    check("multu_max_lo_const", bus.lo_o, 32'h0000_0001);

    run_check("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lo_const", bus.lo_o, 32'hFFFF_FFFD);
    check("div_m7_2_hi_const", bus.hi_o, 32'hFFFF_FFFF);

    run_check("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", bus.lo_o, 32'h8000_0000);
    check("div_ovf_hi_const", bus.hi_o, 32'h0);

    run_check("divu_by0", 2'b11, 32'd100, 32'd0);
    check1("divu_by0_dz_const", bus.dz_o, 1'b1);
    check("divu_by0_hi_const", bus.hi_o, 32'h64);
    run_check("multu_3_4", 2'b01, 32'd3, 32'd4);
    check1("multu_3_4_dz_const", bus.dz_o, 1'b0);
    check("multu_3_4_lo_const", bus.lo_o, 32'd12);

    run_check("div_s_by0", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_check("mult_after_dz", 2'b00, 32'h8000_0000, 32'h8000_0000);

    // start pulsed mid-RUN must not disturb the operation in flight
    model(2'b10, 32'hFFFF_8000, 32'd123, ehi, elo, edz);
    start_op(2'b10, 32'hFFFF_8000, 32'd123);
    repeat (4) @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.src1_i  = 32'd5;
    bus.src2_i  = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(5);
    check_result("ignored_start");
    @(posedge clk); #1;
    check1("ignored_start_no_queue", bus.busy_o, 1'b0);

    // start held in DONE: back-to-back accept with no IDLE cycle
    model(2'b00, 32'hFFFF_FFF0, 32'd9, ehi, elo, edz);
    start_op(2'b00, 32'hFFFF_FFF0, 32'd9);
    wait_done(0);
    check_result("b2b_first");
    bus.start_i = 1'b1;
    bus.op_i    = 2'b11;
    bus.src1_i  = 32'd1000;
    bus.src2_i  = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check1("b2b_busy", bus.busy_o, 1'b1);
    check_result("b2b_old_held");
    model(2'b11, 32'd1000, 32'd7, ehi, elo, edz);
    wait_done(0);
    check_result("b2b_second");
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            (($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom);
      run_check("random", rop, ra, rb);
    end

    // asynchronous reset mid-RUN with a nonzero result and dz set
    run_check("pre_rst_dz", 2'b11, 32'hDEAD_BEEF, 32'd0);
    start_op(2'b00, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("async_rst_busy", bus.busy_o, 1'b0);
    check1("async_rst_done", bus.done_o, 1'b0);
    check1("async_rst_dz", bus.dz_o, 1'b0);
    check("async_rst_hi", bus.hi_o, 32'h0);
    check("async_rst_lo", bus.lo_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("post_rst_idle", bus.busy_o, 1'b0);
    check("post_rst_lo_held", bus.lo_o, 32'h0);
    run_check("post_rst_op", 2'b10, 32'd77, 32'hFFFF_FFF5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
